// File: rtl/sram1_pkg.sv
// Shared types and helpers for the SRAM1 memory-side responder.
package sram1_pkg;

  typedef enum logic {CLEAR, READY} sram1_resp_state_t;

  localparam int SRAM1_ADDR_W = 8;
  localparam int SRAM1_DATA_W = 8;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_par(input logic [SRAM1_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram1_rd_pipe.sv
// READ_LAT-deep delay line carrying read valid, data and parity-error flag.
// Data stages only load on a valid word, so the output holds its last valid value.
module sram1_rd_pipe #(
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_perr,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr
);

  logic              vld_q  [READ_LAT];
  logic              vld_d  [READ_LAT];
  logic [DATA_W-1:0] dat_q  [READ_LAT];
  logic [DATA_W-1:0] dat_d  [READ_LAT];
  logic              perr_q [READ_LAT];
  logic              perr_d [READ_LAT];

  always_comb begin
    vld_d[0]  = in_vld;
    dat_d[0]  = in_vld ? in_data : dat_q[0];
    perr_d[0] = in_vld & in_perr;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      dat_d[i]  = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      perr_d[i] = vld_q[i-1] & perr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        dat_q[i]  <= '0;
        perr_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_q[i]  <= vld_d[i];
        dat_q[i]  <= dat_d[i];
        perr_q[i] <= perr_d[i];
      end
    end
  end

  assign out_vld  = vld_q[READ_LAT-1];
  assign out_data = dat_q[READ_LAT-1];
  assign out_perr = perr_q[READ_LAT-1];

endmodule

// File: rtl/sram1_responder.sv
// SRAM1 memory-side responder: self-clearing byte array with write-first read forwarding.
// Optional stored parity is enabled by defining SRAM1_PARITY_EN.
module sram1_responder
  import sram1_pkg::*;
#(
  parameter int ADDR_W   = SRAM1_ADDR_W,
  parameter int DATA_W   = SRAM1_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_par_flip,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy,
  output logic              req_drop,
  output logic              parity_err
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef SRAM1_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  sram1_resp_state_t state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;
  logic              req_drop_q;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              rd_acc;
  logic              wr_acc;
  logic              rd_perr;

  always_comb begin
    rd_acc = r_en && (state_q == READY);
    wr_acc = w_en && (state_q == READY);
  end

`ifdef SRAM1_PARITY_EN
  // w_par_flip lets software plant a bad parity bit for error-path testing.
  always_comb wr_word = {even_par(w_data) ^ w_par_flip, w_data};
`else
  logic unused_par_flip;
  assign unused_par_flip = w_par_flip;
  always_comb wr_word = w_data;
`endif

  // CLEAR owns the write port; an all-zero word also has correct even parity.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = wr_word;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    if (wr_acc && (w_addr == r_addr)) begin
      rd_word = wr_word;
    end else begin
      rd_word = mem_q[r_addr];
    end
  end

`ifdef SRAM1_PARITY_EN
  always_comb rd_perr = (even_par(rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
`else
  always_comb rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      req_drop_q <= 1'b0;
    end else begin
      req_drop_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_cnt_q  <= clr_cnt_q + 1'b1;
          req_drop_q <= r_en | w_en;
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign req_drop = req_drop_q;

  sram1_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_data  (rd_word[DATA_W-1:0]),
    .in_perr  (rd_perr),
    .out_vld  (r_valid),
    .out_data (r_data),
    .out_perr (parity_err)
  );

endmodule
